// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin scheduler that shares one byte-level UART transmitter among
// NUM_REQ word producers. A granted 32-bit word is latched, then streamed
// LSB-byte-first (low BYTES bytes) over a valid/ready byte interface.
//
// Parameters:
//   NUM_REQ  number of requesters, 2..8
//   BYTES    bytes sent per granted word, 1..4
//
// Ports:
//   clk        system clock
//   ap_rstn    asynchronous active-low reset
//   req_valid  [NUM_REQ]     requester i has a word pending
//   req_data   [NUM_REQ*32]  word of requester i at [32*i +: 32]
//   req_ready  [NUM_REQ]     one-hot accept, asserted only in IDLE
//   tx_valid                 byte on tx_data offered to the transmitter
//   tx_data    [8]           byte to transmit
//   tx_ready                 transmitter accepts tx_data this cycle
//   grant_id   [3]           index of the requester being served
//   busy                     high whenever the FSM is not in IDLE
//
// Build option:
//   UART_ARB_HEADER_EN  when defined, every word is preceded by the header
//                       byte 8'hA0 | grant_id (HDR state compiled in).
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int BYTES   = 4
) (
  input  logic                    clk,
  input  logic                    ap_rstn,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  input  logic                    tx_ready,
  output logic [2:0]              grant_id,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
`ifdef UART_ARB_HEADER_EN
    S_DONE = 2'd2,
    S_HDR  = 2'd3
`else
    S_DONE = 2'd2
`endif
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [2:0]   last_grant;
  logic [31:0]  shift;
  logic [1:0]   byte_cnt;

  logic         pick_found;
  logic [2:0]   pick_idx;
  logic [31:0]  pick_word;
  logic         accept;
  logic         last_byte;

  assign last_byte = (byte_cnt == 2'(BYTES - 1));
  assign busy      = (state != S_IDLE);

  // Round-robin pick: first pending requester strictly above last_grant,
  // otherwise wrap around and take the lowest pending one.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && req_valid[i] && (i > int'(last_grant))) begin
        pick_found = 1'b1;
        pick_idx   = 3'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && req_valid[i]) begin
        pick_found = 1'b1;
        pick_idx   = 3'(i);
      end
    end
  end

  // Word mux and one-hot accept. req_ready is also masked by the reset
  // input so that it drops immediately while reset is asserted, even if
  // requesters keep their valids high.
  always_comb begin
    accept    = (state == S_IDLE) && pick_found && ap_rstn;
    pick_word = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == 3'(i)) begin
        pick_word    = req_data[32*i +: 32];
        req_ready[i] = accept;
      end
    end
  end

  // Next-state and byte-side outputs.
  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    case (state)
      S_IDLE: begin
        if (accept) begin
`ifdef UART_ARB_HEADER_EN
          state_nxt = S_HDR;
`else
          state_nxt = S_SEND;
`endif
        end
      end
`ifdef UART_ARB_HEADER_EN
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = 8'hA0 | {5'b0, grant_id};
        if (tx_ready) state_nxt = S_SEND;
      end
`endif
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = shift[7:0];
        if (tx_ready && last_byte) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge ap_rstn) begin
    if (!ap_rstn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Datapath registers. The shift register is reset too: a dropped partial
  // word must never leak its remaining bytes after reset.
  always_ff @(posedge clk or negedge ap_rstn) begin
    if (!ap_rstn) begin
      shift      <= '0;
      byte_cnt   <= '0;
      grant_id   <= '0;
      last_grant <= 3'(NUM_REQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            shift    <= pick_word;
            grant_id <= pick_idx;
            byte_cnt <= '0;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            shift    <= shift >> 8;
            // Return to zero on the last byte so the count stays <= BYTES-1.
            byte_cnt <= last_byte ? 2'd0 : byte_cnt + 2'd1;
          end
        end
        S_DONE: begin
          last_grant <= grant_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter. One instance with NUM_REQ=4,
// BYTES=4 and one with NUM_REQ=4, BYTES=1. A cycle table covers the basic
// word, stalls and pointer wrap; hand-written sequences cover round-robin
// order, backpressure, mid-transfer reset and the single-byte variant.
// Expected header bytes are included when UART_ARB_HEADER_EN is defined.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         ap_rstn;

  // BYTES=4 instance
  logic [3:0]   req_valid;
  logic [31:0]  word [4];
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         tx_valid;
  logic [7:0]   tx_data;
  logic         tx_ready;
  logic [2:0]   grant_id;
  logic         busy;

  // BYTES=1 instance
  logic [3:0]   b1_req_valid;
  logic [31:0]  b1_word [4];
  logic [127:0] b1_req_data;
  logic [3:0]   b1_req_ready;
  logic         b1_tx_valid;
  logic [7:0]   b1_tx_data;
  logic         b1_tx_ready;
  logic [2:0]   b1_grant_id;
  logic         b1_busy;

  assign req_data    = {word[3], word[2], word[1], word[0]};
  assign b1_req_data = {b1_word[3], b1_word[2], b1_word[1], b1_word[0]};

  uart_tx_arbiter #(.NUM_REQ(4), .BYTES(4)) u_dut (
    .clk       (clk),
    .ap_rstn   (ap_rstn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .BYTES(1)) u_dut_b1 (
    .clk       (clk),
    .ap_rstn   (ap_rstn),
    .req_valid (b1_req_valid),
    .req_data  (b1_req_data),
    .req_ready (b1_req_ready),
    .tx_valid  (b1_tx_valid),
    .tx_data   (b1_tx_data),
    .tx_ready  (b1_tx_ready),
    .grant_id  (b1_grant_id),
    .busy      (b1_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the check point of the next cycle (2 units after posedge).
  task automatic at();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    ap_rstn      = 1'b0;
    req_valid    = '0;
    b1_req_valid = '0;
    repeat (2) @(posedge clk);
    #2;
    ap_rstn = 1'b1;
  endtask

  // Called at the check point of an accept cycle with inputs settled.
  // Walks through the full word for the BYTES=4 instance and returns at
  // the check point of the following IDLE cycle.
  task automatic send_word(input int g, input logic [31:0] w);
    check("accept_ready", 32'(req_ready), 32'(1 << g));
    check("accept_busy", 32'(busy), 32'd0);
    at();
    check("ready_pulse", 32'(req_ready), 32'd0);
    check("grant_id", 32'(grant_id), 32'(g));
    check("busy_on", 32'(busy), 32'd1);
`ifdef UART_ARB_HEADER_EN
    check("hdr_valid", 32'(tx_valid), 32'd1);
    check("hdr_byte", 32'(tx_data), 32'(8'hA0 | 8'(g)));
    at();
`endif
    for (int b = 0; b < 4; b++) begin
      if (b > 0) at();
      check("byte_valid", 32'(tx_valid), 32'd1);
      check("byte_data", 32'(tx_data), 32'(w[8*b +: 8]));
    end
    at();
    check("done_valid", 32'(tx_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd1);
    at();
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  typedef struct packed {
    logic [3:0] rv;
    logic       rdy;
    logic [3:0] e_rr;
    logic       e_tv;
    logic [7:0] e_data;
    logic       e_busy;
    logic [2:0] e_grant;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    ap_rstn      = 1'b0;
    req_valid    = '0;
    tx_ready     = 1'b1;
    b1_req_valid = '0;
    b1_tx_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      word[i]    = '0;
      b1_word[i] = '0;
    end
    #3;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    do_reset();

    // ---------------- table: single word, stall, wrap ----------------
    //               rv     rdy  e_rr   tv  data   busy g
    vecs.push_back({4'b0001, 1'b1, 4'b0001, 1'b0, 8'h00, 1'b0, 3'd0});
`ifdef UART_ARB_HEADER_EN
    vecs.push_back({4'b0000, 1'b1, 4'b0000, 1'b1, 8'hA0, 1'b1, 3'd0});
`endif
    vecs.push_back({4'b0000, 1'b1, 4'b0000, 1'b1, 8'h44, 1'b1, 3'd0});
    vecs.push_back({4'b0000, 1'b1, 4'b0000, 1'b1, 8'h33, 1'b1, 3'd0});
    vecs.push_back({4'b0000, 1'b0, 4'b0000, 1'b1, 8'h22, 1'b1, 3'd0});
    vecs.push_back({4'b0010, 1'b0, 4'b0000, 1'b1, 8'h22, 1'b1, 3'd0});
    vecs.push_back({4'b0000, 1'b1, 4'b0000, 1'b1, 8'h22, 1'b1, 3'd0});
    vecs.push_back({4'b0000, 1'b1, 4'b0000, 1'b1, 8'h11, 1'b1, 3'd0});
    vecs.push_back({4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b1, 3'd0});
    vecs.push_back({4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0, 3'd0});
    // last_grant is 0: requester 3 wins over requester 0.
    vecs.push_back({4'b1001, 1'b1, 4'b1000, 1'b0, 8'h00, 1'b0, 3'd0});
`ifdef UART_ARB_HEADER_EN
    vecs.push_back({4'b0000, 1'b1, 4'b0000, 1'b1, 8'hA3, 1'b1, 3'd3});
`endif
    vecs.push_back({4'b0000, 1'b1, 4'b0000, 1'b1, 8'h0D, 1'b1, 3'd3});

    word[0] = 32'h11223344;
    word[3] = 32'hCAFEF00D;
    foreach (vecs[k]) begin
      at();
      req_valid = vecs[k].rv;
      tx_ready  = vecs[k].rdy;
      #1;
      check($sformatf("tbl%0d_req_ready", k), 32'(req_ready), 32'(vecs[k].e_rr));
      check($sformatf("tbl%0d_tx_valid", k), 32'(tx_valid), 32'(vecs[k].e_tv));
      if (vecs[k].e_tv)
        check($sformatf("tbl%0d_tx_data", k), 32'(tx_data), 32'(vecs[k].e_data));
      check($sformatf("tbl%0d_busy", k), 32'(busy), 32'(vecs[k].e_busy));
      check($sformatf("tbl%0d_grant", k), 32'(grant_id), 32'(vecs[k].e_grant));
    end

    // ---------------- round-robin with all requesters pending ----------------
    do_reset();
    for (int i = 0; i < 4; i++) word[i] = 32'hA0000000 + 32'(i);
    tx_ready  = 1'b1;
    req_valid = 4'b1111;
    #1;
    begin
      int order [5];
      order = '{0, 1, 2, 3, 0};
      for (int n = 0; n < 5; n++) send_word(order[n], 32'hA0000000 + 32'(order[n]));
    end

    // ---------------- backpressure at byte 2 ----------------
    do_reset();
    word[0]   = 32'h11223344;
    tx_ready  = 1'b1;
    req_valid = 4'b0001;
    #1;
    check("bp_accept", 32'(req_ready), 32'd1);
    at();
`ifdef UART_ARB_HEADER_EN
    at();
`endif
    req_valid = 4'b0000;
    word[0]   = 32'hDEADBEEF;   // latched copy must be unaffected
    #1;
    check("bp_b0", 32'(tx_data), 32'h44);
    at();
    check("bp_b1", 32'(tx_data), 32'h33);
    at();
    tx_ready = 1'b0;
    #1;
    check("bp_stall_valid", 32'(tx_valid), 32'd1);
    check("bp_stall_data", 32'(tx_data), 32'h22);
    for (int i = 0; i < 4; i++) begin
      at();
      check("bp_stall_valid", 32'(tx_valid), 32'd1);
      check("bp_stall_data", 32'(tx_data), 32'h22);
    end
    at();
    tx_ready = 1'b1;
    #1;
    check("bp_release_data", 32'(tx_data), 32'h22);
    at();
    check("bp_resume_data", 32'(tx_data), 32'h11);
    check("bp_resume_valid", 32'(tx_valid), 32'd1);
    at();
    check("bp_done_valid", 32'(tx_valid), 32'd0);

    // ---------------- reset mid-transfer ----------------
    do_reset();
    word[0]   = 32'h11223344;
    word[1]   = 32'h55667788;
    tx_ready  = 1'b1;
    req_valid = 4'b0001;
    #1;
    send_word(0, 32'h11223344);
    req_valid = 4'b0011;
    #1;
    check("mr_accept1", 32'(req_ready), 32'b0010);
    at();
`ifdef UART_ARB_HEADER_EN
    at();
`endif
    check("mr_b0", 32'(tx_data), 32'h88);
    at();
    check("mr_b1", 32'(tx_data), 32'h77);
    at();
    check("mr_b2", 32'(tx_data), 32'h66);
    #1;
    ap_rstn = 1'b0;
    #1;
    check("mr_rst_valid", 32'(tx_valid), 32'd0);
    check("mr_rst_busy", 32'(busy), 32'd0);
    check("mr_rst_ready", 32'(req_ready), 32'd0);
    check("mr_rst_grant", 32'(grant_id), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    ap_rstn = 1'b1;
    #1;
    send_word(0, 32'h11223344);
    req_valid = 4'b0000;

    // ---------------- BYTES=1 instance, requesters 1 and 3 ----------------
    at();
    b1_word[1]   = 32'h000000B1;
    b1_word[3]   = 32'h000000B3;
    b1_tx_ready  = 1'b1;
    b1_req_valid = 4'b1010;
    #1;
    check("b1_accept1", 32'(b1_req_ready), 32'b0010);
    at();
`ifdef UART_ARB_HEADER_EN
    check("b1_hdr1", 32'(b1_tx_data), 32'hA1);
    at();
`endif
    check("b1_valid1", 32'(b1_tx_valid), 32'd1);
    check("b1_data1", 32'(b1_tx_data), 32'hB1);
    check("b1_grant1", 32'(b1_grant_id), 32'd1);
    at();
    check("b1_done1", 32'(b1_tx_valid), 32'd0);
    check("b1_done1_busy", 32'(b1_busy), 32'd1);
    at();
    check("b1_accept3", 32'(b1_req_ready), 32'b1000);
    check("b1_idle_busy", 32'(b1_busy), 32'd0);
    at();
`ifdef UART_ARB_HEADER_EN
    check("b1_hdr3", 32'(b1_tx_data), 32'hA3);
    at();
`endif
    check("b1_data3", 32'(b1_tx_data), 32'hB3);
    check("b1_grant3", 32'(b1_grant_id), 32'd3);
    at();
    check("b1_done3", 32'(b1_tx_valid), 32'd0);
    at();
    check("b1_accept1_again", 32'(b1_req_ready), 32'b0010);
    b1_req_valid = 4'b0000;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one byte-level UART transmitter among up to eight requesters. Each requester offers a 32-bit word; the arbiter grants one, latches the word, and streams it LSB-byte-first into the transmitter over a valid/ready byte interface. It sits between the application-side word producers and the UART TX byte engine.

## Interface
- NUM_REQ, 4, number of requesters, legal 2..8
- BYTES, 4, bytes sent per granted word, legal 1..4 (low BYTES bytes of the word)
- clk  in  1  system clock
- ap_rstn  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  requester i has a word pending
- req_data  in  NUM_REQ*32  word of requester i at bits [32*i+31 : 32*i]
- req_ready  out  NUM_REQ  one-hot accept; transfer when req_valid[i] && req_ready[i]
- tx_valid  out  1  byte on tx_data is offered to the transmitter
- tx_data  out  8  byte to transmit
- tx_ready  in  1  transmitter accepts tx_data this cycle
- grant_id  out  3  index of the requester currently being served
- busy  out  1  high from acceptance until the DONE state ends

## Operation
- States: IDLE, HDR (only with the header feature), SEND, DONE.
- IDLE: if any req_valid, pick g = first set bit searching upward from (last_grant+1) mod NUM_REQ, wrapping. req_ready[g] = 1 combinationally in this cycle only; at the clock edge, latch req_data[g] into the shift register, set grant_id = g, clear byte_cnt, and go to HDR or SEND. If no req_valid, stay; req_ready = 0.
- HDR: tx_valid = 1, tx_data = 8'hA0 | grant_id. On tx_ready go to SEND.
- SEND: tx_valid = 1, tx_data = shift[7:0]. On tx_ready, shift right by 8 and increment byte_cnt. If byte_cnt == BYTES-1 at the handshake, go to DONE; otherwise stay.
- DONE: one cycle, tx_valid = 0, last_grant <= grant_id, go to IDLE.
- req_valid is sampled only in IDLE. Deasserting it in any other state has no effect on the word in flight.
- req_ready is zero in every state except IDLE.
- byte_cnt is 2 bits and never exceeds BYTES-1.
- busy = (state != IDLE).
- Reset values:
  - state = IDLE
  - last_grant = NUM_REQ-1, so requester 0 has first priority
  - grant_id = 0, busy = 0, tx_valid = 0, tx_data = 0
  - req_ready = 0, shift register = 0, byte_cnt = 0

## Timing
- Accept in cycle N (IDLE, req_valid) gives tx_valid = 1 with the first byte in cycle N+1.
- Once tx_valid is asserted, it and tx_data hold stable until the tx_ready handshake. They never drop or change without one.
- Each byte takes one cycle when tx_ready is held high. Backpressure stalls the state in place indefinitely.
- Last handshake in cycle M gives DONE in M+1 and IDLE in M+2. The next accept is possible in M+2.
- Minimum period per word is BYTES+2 cycles, or BYTES+3 with the header.
- If the granted requester reasserts in the following IDLE together with others, the others win because the pointer has advanced past it.
- Reset asserted mid-transfer: all outputs go to reset values immediately (asynchronously). The partial word is dropped, with no retry.

## Configuration
- UART_ARB_HEADER_EN defined: HDR state is compiled in. Every word is preceded by the header byte 8'hA0 | grant_id.
- UART_ARB_HEADER_EN undefined: HDR state and its logic are absent. IDLE goes directly to SEND.

## Test plan
- Single word: NUM_REQ=4, BYTES=4, tx_ready=1, req_valid=4'b0001, word 32'h11223344 -> req_ready[0] pulses 1 cycle; tx_data 44,33,22,11 on 4 consecutive cycles; busy low 2 cycles after the last byte.
- Round-robin: req_valid=4'b1111 held, words 32'hA0000000+i -> grant order 0,1,2,3,0; each req_ready is a single-cycle pulse.
- Backpressure: tx_ready low for 5 cycles at byte 2 -> tx_valid stays 1 and tx_data stays 8'h22 throughout; resumes with 8'h11 after tx_ready rises.
- Header: with UART_ARB_HEADER_EN, requester 2 word 32'h000000FF -> bytes A2, FF, 00, 00, 00.
- BYTES=1 with requesters 1 and 3 pending -> one byte each; grant 1 then 3; 3 cycles per word.
- Reset during byte 3 -> tx_valid, busy and req_ready go 0 asynchronously; after release, requester 0 has priority and its word is sent from byte 0.
